// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the datapath and seq_alu.
//
// Signals:
//   in_valid  - request strobe from the datapath.
//   in_ready  - ALU can take a request this cycle.
//   op, mode  - opcode and width select (1 = full word, 0 = half word).
//   a, b      - operands; b also carries the shift/rotate amount.
//   done      - one-cycle pulse when result and flags are valid.
//   result    - registered result.
//   zero, sign, carry, overflow - persistent status register.
//
// Modports: master drives requests, slave (the ALU) drives responses.
interface seq_alu_if #(
  parameter int WIDTH = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             sign;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op, mode, a, b,
    input  in_ready, done, result, zero, sign, carry, overflow
  );

  modport slave (
    input  in_valid, op, mode, a, b,
    output in_ready, done, result, zero, sign, carry, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a persistent status register.
//
// Logic/add/subtract ops finish in one cycle. Shifts and rotates move one
// bit per cycle. MUL is a shift-add multiplier consuming one multiplier
// bit per cycle. The effective width is WIDTH (mode=1) or HALF (mode=0);
// result bits above the effective width are always zero.
//
// Ports:
//   clk  - rising-edge clock.
//   rst  - synchronous, active-high reset.
//   bus  - seq_alu_if slave modport (handshake, operands, result, flags).
module seq_alu #(
  parameter int WIDTH = 20,
  parameter int HALF  = 10
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] FULL_MASK = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [WIDTH-1:0] FULL_TOP  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] HALF_TOP  = WIDTH'(1) << (HALF - 1);

  localparam logic [3:0] OP_NOT = 4'd0,  OP_AND = 4'd1,  OP_OR  = 4'd2,  OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SUB = 4'd6,  OP_SBB = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8,  OP_DEC = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11;
  localparam logic [3:0] OP_ROL = 4'd12, OP_ROR = 4'd13, OP_MUL = 4'd14, OP_CMP = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               sign_q, sign_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  // Sign bit of an effective-width value.
  function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic m);
    return m ? v[WIDTH-1] : v[HALF-1];
  endfunction

  // Operands masked to the requested width, and the capped shift amount.
  logic [WIDTH-1:0] mask_in, a_in, b_in;
  logic [CW-1:0]    ew_in, amt_in;
  logic             is_shift_in;

  always_comb begin
    mask_in     = bus.mode ? FULL_MASK : HALF_MASK;
    a_in        = bus.a & mask_in;
    b_in        = bus.b & mask_in;
    ew_in       = bus.mode ? CW'(WIDTH) : CW'(HALF);
    amt_in      = (b_in >= WIDTH'(ew_in)) ? ew_in : b_in[CW-1:0];
    is_shift_in = (bus.op == OP_SHL) || (bus.op == OP_SHR) ||
                  (bus.op == OP_ROL) || (bus.op == OP_ROR);
  end

  // Single-cycle datapath. Sum and difference are formed one bit wider than
  // the word so that bit EW holds the carry (or borrow, which shows up as the
  // wrapped sign of a negative difference).
  logic [WIDTH-1:0] opnd, sum_r, dif_r, alu_r;
  logic [WIDTH:0]   sum_w, dif_w;
  logic             cin, sa, so, add_c, add_v, sub_c, sub_v, alu_c, alu_v, alu_wr;

  always_comb begin
    opnd = b_in;
    cin  = 1'b0;
    if (bus.op == OP_ADC || bus.op == OP_SBB) cin = carry_q;
    if (bus.op == OP_INC || bus.op == OP_DEC) opnd = WIDTH'(1);

    sum_w = {1'b0, a_in} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
    dif_w = {1'b0, a_in} - {1'b0, opnd} - {{WIDTH{1'b0}}, cin};
    sum_r = sum_w[WIDTH-1:0] & mask_in;
    dif_r = dif_w[WIDTH-1:0] & mask_in;

    sa    = msb_of(a_in, bus.mode);
    so    = msb_of(opnd, bus.mode);
    add_c = bus.mode ? sum_w[WIDTH] : sum_w[HALF];
    sub_c = bus.mode ? dif_w[WIDTH] : dif_w[HALF];
    add_v = (sa == so) && (msb_of(sum_r, bus.mode) != sa);
    sub_v = (sa != so) && (msb_of(dif_r, bus.mode) != sa);

    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    alu_wr = 1'b1;
    case (bus.op)
      OP_NOT: alu_r = ~a_in & mask_in;
      OP_AND: alu_r = a_in & b_in;
      OP_OR:  alu_r = a_in | b_in;
      OP_XOR: alu_r = a_in ^ b_in;
      OP_ADD, OP_ADC, OP_INC: begin
        alu_r = sum_r;
        alu_c = add_c;
        alu_v = add_v;
      end
      OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
        alu_r  = dif_r;
        alu_c  = sub_c;
        alu_v  = sub_v;
        alu_wr = (bus.op != OP_CMP);
      end
      default: alu_r = '0;
    endcase
  end

  // One iteration step for shifts/rotates and the shift-add multiplier.
  logic [WIDTH-1:0]   mask_q, step_work, mul_lo;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               msb_w, step_out, mul_hi;

  always_comb begin
    mask_q    = mode_q ? FULL_MASK : HALF_MASK;
    msb_w     = msb_of(work_q, mode_q);
    step_work = work_q >> 1;
    step_out  = work_q[0];
    case (op_q)
      OP_SHL: begin
        step_work = (work_q << 1) & mask_q;
        step_out  = msb_w;
      end
      OP_ROL: begin
        step_work = ((work_q << 1) | {{(WIDTH-1){1'b0}}, msb_w}) & mask_q;
        step_out  = msb_w;
      end
      OP_ROR: begin
        step_work = (work_q >> 1) | (work_q[0] ? (mode_q ? FULL_TOP : HALF_TOP) : '0);
        step_out  = work_q[0];
      end
      default: begin
        step_work = work_q >> 1;
        step_out  = work_q[0];
      end
    endcase

    acc_nxt = work_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_lo  = acc_nxt[WIDTH-1:0] & mask_q;
    mul_hi  = mode_q ? (|acc_nxt[2*WIDTH-1:WIDTH]) : (|acc_nxt[2*WIDTH-1:HALF]);
  end

  // Next-state logic. Flags only change on the transition into DONE, so the
  // stored carry seen by ADC/SBB is always that of the previous operation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mode_d   = mode_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d   = bus.op;
          mode_d = bus.mode;
          if (bus.op == OP_MUL) begin
            state_d = ITER;
            work_d  = b_in;
            mcand_d = {{WIDTH{1'b0}}, a_in};
            acc_d   = '0;
            cnt_d   = ew_in;
          end else if (is_shift_in && amt_in != '0) begin
            state_d = ITER;
            work_d  = a_in;
            cnt_d   = amt_in;
          end else if (is_shift_in) begin
            state_d  = DONE;
            result_d = a_in;
            zero_d   = (a_in == '0);
            sign_d   = msb_of(a_in, bus.mode);
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
          end else begin
            state_d = DONE;
            if (alu_wr) result_d = alu_r;
            zero_d  = (alu_r == '0);
            sign_d  = msb_of(alu_r, bus.mode);
            carry_d = alu_c;
            ovf_d   = alu_v;
          end
        end
      end
      ITER: begin
        cnt_d   = cnt_q - CW'(1);
        work_d  = step_work;
        mcand_d = mcand_q << 1;
        acc_d   = acc_nxt;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (op_q == OP_MUL) begin
            result_d = mul_lo;
            zero_d   = (mul_lo == '0);
            sign_d   = msb_of(mul_lo, mode_q);
            carry_d  = mul_hi;
            ovf_d    = mul_hi;
          end else begin
            result_d = step_work;
            zero_d   = (step_work == '0);
            sign_d   = msb_of(step_work, mode_q);
            carry_d  = step_out;
            ovf_d    = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state.
  assign done_d  = (state_d == DONE);
  assign ready_d = (state_d == IDLE);

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mode_q   <= 1'b0;
      work_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.sign     = sign_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random transactions for seq_alu, compared
// against an arithmetic reference model of the opcode rules.
module tb_seq_alu;

  localparam int WIDTH = 20;
  localparam int HALF  = 10;

  logic clk = 1'b0;
  logic rst;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH), .HALF(HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference status register and result.
  longint unsigned m_result;
  bit m_zero, m_sign, m_carry, m_ovf;

  // Interpret an ew-bit value as two's complement.
  function automatic longint sx(input longint unsigned v, input int ew);
    longint unsigned half;
    half = 64'd1 << (ew - 1);
    if (v >= half) return longint'(v) - (longint'(1) << ew);
    return longint'(v);
  endfunction

  // Applies one operation to the model state; returns the expected latency.
  function automatic int modelOp(input int op, input bit mode,
                                 input longint unsigned a, input longint unsigned b);
    int ew, n, lat;
    longint unsigned mask, am, bm, r, s, p, addend, cin;
    longint sres, hi_lim, lo_lim;
    bit c, v, wr;
    ew     = mode ? WIDTH : HALF;
    mask   = (64'd1 << ew) - 1;
    am     = a & mask;
    bm     = b & mask;
    hi_lim = (longint'(1) << (ew - 1)) - 1;
    lo_lim = -(longint'(1) << (ew - 1));
    r = 0; c = 0; v = 0; wr = 1; lat = 1;
    case (op)
      0: r = ~am & mask;
      1: r = am & bm;
      2: r = am | bm;
      3: r = am ^ bm;
      4, 5, 8: begin
        addend = (op == 8) ? 64'd1 : bm;
        cin    = (op == 5) ? longint'(m_carry) : 0;
        s      = am + addend + cin;
        r      = s & mask;
        c      = (s > mask);
        sres   = sx(am, ew) + sx(addend, ew) + longint'(cin);
        v      = (sres > hi_lim) || (sres < lo_lim);
      end
      6, 7, 9, 15: begin
        addend = (op == 9) ? 64'd1 : bm;
        cin    = (op == 7) ? longint'(m_carry) : 0;
        c      = (am < addend + cin);
        r      = (am - addend - cin) & mask;
        sres   = sx(am, ew) - sx(addend, ew) - longint'(cin);
        v      = (sres > hi_lim) || (sres < lo_lim);
        wr     = (op != 15);
      end
      10, 11, 12, 13: begin
        n   = (bm > longint'(ew)) ? ew : int'(bm);
        lat = n + 1;
        case (op)
          10: r = (am << n) & mask;
          11: r = am >> n;
          12: r = ((am << n) | (am >> (ew - n))) & mask;
          default: r = ((am >> n) | (am << (ew - n))) & mask;
        endcase
        if (n > 0) begin
          case (op)
            10: c = ((am >> (ew - n)) & 1) != 0;
            11: c = ((am >> (n - 1)) & 1) != 0;
            12: c = (r & 1) != 0;
            default: c = ((r >> (ew - 1)) & 1) != 0;
          endcase
        end
      end
      default: begin
        p   = am * bm;
        r   = p & mask;
        c   = (p >> ew) != 0;
        v   = c;
        lat = ew + 1;
      end
    endcase
    if (wr) m_result = r;
    m_zero  = (r == 0);
    m_sign  = ((r >> (ew - 1)) & 1) != 0;
    m_carry = c;
    m_ovf   = v;
    return lat;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, " result"},   64'(bus.result),   m_result);
    checkOutput({tag, " zero"},     64'(bus.zero),     64'(m_zero));
    checkOutput({tag, " sign"},     64'(bus.sign),     64'(m_sign));
    checkOutput({tag, " carry"},    64'(bus.carry),    64'(m_carry));
    checkOutput({tag, " overflow"}, 64'(bus.overflow), 64'(m_ovf));
  endtask

  // Full transaction: wait for ready, accept, wait for done, then check.
  task automatic applyStimulus(input int op, input bit mode, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input string tag);
    int exp_lat, lat, waited;
    exp_lat = modelOp(op, mode, a, b);
    @(negedge clk);
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = op[3:0];
    bus.mode     = mode;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    checkFlags(tag);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_lat, lat, seen;
    int op, ew;
    bit mode;
    logic [WIDTH-1:0] ra, rb;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 4'd0;
    bus.mode     = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    m_result = 0; m_zero = 0; m_sign = 0; m_carry = 0; m_ovf = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset done",     64'(bus.done),     64'd0);
    checkFlags("reset");

    applyStimulus(4,  1'b1, 20'hFFFFF, 20'h00001, "add_wrap");
    applyStimulus(5,  1'b1, 20'h00000, 20'h00000, "adc_carry");
    applyStimulus(6,  1'b0, 20'hABC05, 20'h7F006, "sub_half");
    applyStimulus(10, 1'b1, 20'h80001, 20'd3,     "shl3");
    applyStimulus(10, 1'b1, 20'h80001, 20'd40,    "shl40");
    applyStimulus(13, 1'b1, 20'h80001, 20'd20,    "ror20");
    applyStimulus(12, 1'b0, 20'h002AB, 20'd0,     "rol0");
    applyStimulus(15, 1'b1, 20'h00005, 20'h00005, "cmp_eq");
    applyStimulus(14, 1'b1, 20'h00123, 20'h00045, "mul");
    applyStimulus(14, 1'b1, 20'h80000, 20'h00002, "mul_ovf");
    applyStimulus(8,  1'b0, 20'h001FF, 20'h00000, "inc_ovf");
    applyStimulus(9,  1'b1, 20'h00000, 20'h00000, "dec_borrow");

    // Requests during a busy MUL must be ignored.
    exp_lat = modelOp(14, 1'b1, 20'h00ABC, 20'h00321);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd14;
    bus.mode     = 1'b1;
    bus.a        = 20'h00ABC;
    bus.b        = 20'h00321;
    @(posedge clk);
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat <= 3) begin
        checkOutput("busy in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.op       = 4'd4;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.done) seen = 1;
    end
    bus.in_valid = 1'b0;
    checkOutput("busy latency", 64'(lat), 64'(exp_lat));
    checkFlags("busy");

    // Reset in the middle of a MUL: no done pulse for the aborted op.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd14;
    bus.mode     = 1'b1;
    bus.a        = 20'h12345;
    bus.b        = 20'h0F0F0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_result = 0; m_zero = 0; m_sign = 0; m_carry = 0; m_ovf = 0;
    checkOutput("abort in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("abort done",     64'(bus.done),     64'd0);
    checkFlags("abort");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    checkOutput("abort no_done", 64'(seen), 64'd0);
    applyStimulus(5, 1'b1, 20'h00010, 20'h00020, "adc_after_reset");

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      op   = int'($urandom_range(0, 15));
      mode = 1'($urandom_range(0, 1));
      ew   = mode ? WIDTH : HALF;
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      if (op >= 10 && op <= 13) rb = WIDTH'($urandom_range(0, ew + 3));
      applyStimulus(op, mode, ra, rb, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
